// File: rtl/uart_tx_param.sv
// uart_tx_param
// Parametrised UART transmitter with an input FIFO. Queued words are sent as
// start / data (LSB first) / optional parity / stop frames, every bit lasting
// exactly DZIELNIK clock cycles. Frames queued behind each other go out with
// no idle gap between them.
//
// Parameters:
//   SZER     data bits per frame (5..9)
//   DZIELNIK clock cycles per serial bit (>= 2)
//   STOP     stop bits per frame (1 or 2)
//   GLEB     FIFO depth in words (power of 2, >= 2)
//
// Ports:
//   CLK            system clock, rising edge
//   RST_N          asynchronous active-low reset
//   slowo_trans    word to queue
//   start_trans    write strobe, pushes slowo_trans when the FIFO is not full
//   czy_parz       1 = parity bit present (latched when a word is popped)
//   jaki_parz      0 = even parity, 1 = odd parity (latched at pop)
//   wyjscie_trans  serial line, idles high
//   transmisja     high while a frame is in progress or the FIFO is non-empty
//   pelny          FIFO full
//   pusty          FIFO empty
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | line high, waiting for a queued word
// S_START | start bit (0)
// S_DANE  | data bits, LSB first, shreg shifted right per bit
// S_PARZ  | parity bit
// S_STOPB | stop bit(s); pops the next word on the last cycle
module uart_tx_param #(
  parameter int SZER     = 8,
  parameter int DZIELNIK = 16,
  parameter int STOP     = 1,
  parameter int GLEB     = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [SZER-1:0] slowo_trans,
  input  logic            start_trans,
  input  logic            czy_parz,
  input  logic            jaki_parz,
  output logic            wyjscie_trans,
  output logic            transmisja,
  output logic            pelny,
  output logic            pusty
);

  localparam int PW = $clog2(GLEB);
  localparam int CW = $clog2(DZIELNIK);
  localparam int IW = $clog2(SZER + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DANE  = 3'd2;
  localparam logic [2:0] S_PARZ  = 3'd3;
  localparam logic [2:0] S_STOPB = 3'd4;

  logic [SZER-1:0] mem [GLEB];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     cnt, cnt_next;

  logic [2:0]      state;
  logic [CW-1:0]   bit_cnt;
  logic [IW-1:0]   idx;
  logic            stop_cnt;
  logic [SZER-1:0] shreg;
  logic            par_en, par_bit;

  logic push, pop, bit_end, stop_end, frame_last, next_idle;

  assign bit_end    = (bit_cnt == CW'(DZIELNIK - 1));
  assign stop_end   = (stop_cnt == 1'(STOP - 1));
  assign frame_last = (state == S_STOPB) && bit_end && stop_end;

  // A full FIFO rejects the push even if a pop frees a slot on the same edge.
  assign push = start_trans && (cnt != (PW+1)'(GLEB));
  assign pop  = (cnt != '0) && ((state == S_IDLE) || frame_last);

  assign next_idle = ((state == S_IDLE) || frame_last) && !pop;

  always_comb begin
    cnt_next = cnt;
    if (push && !pop)
      cnt_next = cnt + 1'b1;
    else if (pop && !push)
      cnt_next = cnt - 1'b1;
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= slowo_trans;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      pelny      <= 1'b0;
      pusty      <= 1'b1;
      transmisja <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      cnt        <= cnt_next;
      pelny      <= (cnt_next == (PW+1)'(GLEB));
      pusty      <= (cnt_next == '0);
      transmisja <= !next_idle || (cnt_next != '0);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= S_IDLE;
      bit_cnt       <= '0;
      idx           <= '0;
      stop_cnt      <= 1'b0;
      shreg         <= '0;
      par_en        <= 1'b0;
      par_bit       <= 1'b0;
      wyjscie_trans <= 1'b1;
    end else if (pop) begin
      // Shared by the idle pop and the back-to-back pop at the end of a frame.
      shreg         <= mem[rd_ptr];
      par_en        <= czy_parz;
      par_bit       <= (^mem[rd_ptr]) ^ jaki_parz;
      bit_cnt       <= '0;
      state         <= S_START;
      wyjscie_trans <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          wyjscie_trans <= 1'b1;
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt       <= '0;
            idx           <= '0;
            state         <= S_DANE;
            wyjscie_trans <= shreg[0];
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        S_DANE: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (idx == IW'(SZER - 1)) begin
              if (par_en) begin
                state         <= S_PARZ;
                wyjscie_trans <= par_bit;
              end else begin
                state         <= S_STOPB;
                stop_cnt      <= 1'b0;
                wyjscie_trans <= 1'b1;
              end
            end else begin
              idx           <= idx + IW'(1);
              shreg         <= shreg >> 1;
              wyjscie_trans <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        S_PARZ: begin
          if (bit_end) begin
            bit_cnt       <= '0;
            stop_cnt      <= 1'b0;
            state         <= S_STOPB;
            wyjscie_trans <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        S_STOPB: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (stop_end) begin
              state         <= S_IDLE;
              wyjscie_trans <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
          state         <= S_IDLE;
          wyjscie_trans <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

  localparam int A_SZER = 8;
  localparam int A_DZ   = 4;
  localparam int A_STOP = 1;
  localparam int A_GLEB = 4;

  typedef struct {
    bit [15:0] bits;
    int        n;
    int        word;
  } frame_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;

  logic [7:0] slowo_a = '0;
  logic       start_a = 1'b0, czy_a = 1'b0, jaki_a = 1'b0;
  logic       line_a, trans_a, pelny_a, pusty_a;

  logic [6:0] slowo_b = '0;
  logic       start_b = 1'b0;
  logic       line_b, trans_b, pelny_b, pusty_b;

  int n_checks = 0;
  int n_pass   = 0;

  frame_t exp_q[$];
  int     model_cnt = 0;
  bit     mon_in_frame = 0;

  always #5 CLK = ~CLK;

  uart_tx_param #(.SZER(A_SZER), .DZIELNIK(A_DZ), .STOP(A_STOP), .GLEB(A_GLEB)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .slowo_trans(slowo_a), .start_trans(start_a),
    .czy_parz(czy_a), .jaki_parz(jaki_a), .wyjscie_trans(line_a),
    .transmisja(trans_a), .pelny(pelny_a), .pusty(pusty_a));

  uart_tx_param #(.SZER(7), .DZIELNIK(3), .STOP(2), .GLEB(4)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .slowo_trans(slowo_b), .start_trans(start_b),
    .czy_parz(1'b0), .jaki_parz(1'b0), .wyjscie_trans(line_b),
    .transmisja(trans_b), .pelny(pelny_b), .pusty(pusty_b));

  task automatic check(input bit ok, input string name, input int act, input int expv);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  // Reference frame: list of line levels, one entry per bit period.
  function automatic frame_t make_frame(input logic [8:0] word, input int szer,
                                        input bit pe, input bit odd, input int stop);
    frame_t f;
    int ones = 0;
    int k = 0;
    f.bits = '0;
    f.word = int'(word);
    f.bits[k] = 1'b0; k++;
    for (int i = 0; i < szer; i++) begin
      f.bits[k] = word[i];
      ones += int'(word[i]);
      k++;
    end
    if (pe) begin
      f.bits[k] = ones[0] ^ odd;
      k++;
    end
    for (int i = 0; i < stop; i++) begin
      f.bits[k] = 1'b1;
      k++;
    end
    f.n = k;
    return f;
  endfunction

  // Monitor for dut_a: decodes frames cycle by cycle against the scoreboard.
  frame_t cur;
  int     pos = 0;
  int     bad = 0;
  bit     prev_pos = 0;
  always @(posedge CLK) begin
    bit cur_in;
    #1;
    if (!RST_N) begin
      mon_in_frame = 0;
      prev_pos = 0;
    end else begin
      cur_in = mon_in_frame;
      if (!mon_in_frame && prev_pos)
        check(line_a == 1'b0, "start_on_time", int'(line_a), 0);
      if (!mon_in_frame && line_a == 1'b0) begin
        check(exp_q.size() != 0, "unexpected_frame", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          model_cnt--;
          mon_in_frame = 1;
          cur_in = 1;
          pos = 0;
          bad = 0;
        end
      end
      if (mon_in_frame) begin
        if (line_a != cur.bits[pos / A_DZ]) bad++;
        pos++;
        if (pos == cur.n * A_DZ) begin
          check(bad == 0, "frame", bad, 0);
          mon_in_frame = 0;
        end
      end
      check(pusty_a == (model_cnt == 0), "pusty", int'(pusty_a), int'(model_cnt == 0));
      check(pelny_a == (model_cnt == A_GLEB), "pelny", int'(pelny_a), int'(model_cnt == A_GLEB));
      check(trans_a == (cur_in || model_cnt > 0), "transmisja", int'(trans_a),
            int'(cur_in || model_cnt > 0));
      prev_pos = (model_cnt > 0);
    end
  end

  // One stimulus cycle for dut_a. Parity configuration only changes while
  // nothing is queued, so every queued word sees the config it was pushed with;
  // a frame already on the line must be unaffected.
  task automatic drive_cycle(input bit en, input logic [7:0] w,
                             input bit chg, input bit pe, input bit odd);
    @(negedge CLK);
    if (chg && model_cnt == 0) begin
      czy_a  = pe;
      jaki_a = odd;
    end
    start_a = en;
    slowo_a = w;
    if (en && model_cnt < A_GLEB) begin
      exp_q.push_back(make_frame({1'b0, w}, A_SZER, czy_a, jaki_a, A_STOP));
      model_cnt++;
    end
  endtask

  task automatic wait_idle(input bit toggle_cfg);
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      drive_cycle(1'b0, 8'h00, toggle_cfg && ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (model_cnt == 0 && !mon_in_frame) begin
        done = 1;
        break;
      end
    end
    if (!done) check(1'b0, "idle_timeout", model_cnt, 0);
  endtask

  initial begin
    frame_t fb;
    bit seen;

    repeat (3) @(negedge CLK);
    check(line_a == 1'b1, "rst_line", int'(line_a), 1);
    check(trans_a == 1'b0, "rst_transmisja", int'(trans_a), 0);
    check(pelny_a == 1'b0, "rst_pelny", int'(pelny_a), 0);
    check(pusty_a == 1'b1, "rst_pusty", int'(pusty_a), 1);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Directed 0x99 frames: odd parity, even parity, no parity.
    drive_cycle(1'b1, 8'h99, 1'b1, 1'b1, 1'b1);
    wait_idle(1'b1);
    drive_cycle(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    wait_idle(1'b1);
    drive_cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    wait_idle(1'b0);

    // Burst: consecutive pushes until full, last one dropped.
    for (int j = 1; j <= 6; j++)
      drive_cycle(1'b1, 8'(j), 1'b1, 1'b1, 1'b0);
    wait_idle(1'b0);

    // Randomised bursts with random gaps and configurations.
    for (int b = 0; b < 12; b++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int j = 0; j < n; j++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++)
          drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      wait_idle(1'b1);
    end

    // Reset 10 cycles into the first of three queued frames.
    for (int j = 0; j < 3; j++)
      drive_cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (mon_in_frame) begin
        seen = 1;
        break;
      end
    end
    check(seen, "frame_start_timeout", int'(seen), 1);
    repeat (10) @(negedge CLK);
    check(line_a == 1'b0, "pre_reset_line", int'(line_a), 0);
    RST_N = 1'b0;
    #1;
    check(line_a == 1'b1, "async_rst_line", int'(line_a), 1);
    check(trans_a == 1'b0, "async_rst_transmisja", int'(trans_a), 0);
    check(pusty_a == 1'b1, "async_rst_pusty", int'(pusty_a), 1);
    exp_q.delete();
    model_cnt = 0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 150; i++)
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // dut_b: SZER=7, DZIELNIK=3, STOP=2, 7'h55 without parity.
    fb = make_frame(9'h055, 7, 1'b0, 1'b0, 2);
    @(negedge CLK);
    slowo_b = 7'h55;
    start_b = 1'b1;
    @(posedge CLK);
    #1;
    start_b = 1'b0;
    check(trans_b == 1'b1, "b_transmisja_rise", int'(trans_b), 1);
    check(line_b == 1'b1, "b_line_before_pop", int'(line_b), 1);
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK);
      #1;
      check(line_b == fb.bits[i / 3], "b_line", int'(line_b), int'(fb.bits[i / 3]));
      check(trans_b == 1'b1, "b_transmisja", int'(trans_b), 1);
    end
    @(posedge CLK);
    #1;
    check(line_b == 1'b1, "b_idle_line", int'(line_b), 1);
    check(trans_b == 1'b0, "b_transmisja_fall", int'(trans_b), 0);
    check(pusty_b == 1'b1, "b_pusty", int'(pusty_b), 1);

    @(negedge CLK);
    check(exp_q.size() == 0, "leftover_frames", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
